// File: rtl/aes128_keyram_2key_switch.sv
// Ping-pong round-key RAM: two banks of AES-128 key schedules, one read while the other is written.
// Written 64 bits at a time; switch_key swaps the read and write banks.
module aes128_keyram_2key_switch #(
    parameter int unsigned NROUND_KEYS = 11,
    parameter int unsigned WR_WIDTH    = 64
) (
    input  logic                    clk,
    input  logic                    kill,
    input  logic                    en_wr,
    input  logic [WR_WIDTH-1:0]     key_round_wr,
    input  logic                    key_ready,
    input  logic                    switch_key,
    output logic [2*WR_WIDTH-1:0]   key_round_rd,
    output logic                    key_idx
);

    localparam int unsigned NHALVES = 2 * NROUND_KEYS;
    localparam int unsigned RD_W    = $clog2(NROUND_KEYS);
    localparam int unsigned WR_W    = RD_W + 1;

    localparam logic [RD_W-1:0] RD_LAST = RD_W'(NROUND_KEYS - 1);
    localparam logic [WR_W-1:0] WR_LAST = WR_W'(NHALVES - 1);

    logic [WR_WIDTH-1:0]   mem_q [2][NHALVES];

    logic                  key_idx_q, key_idx_d;
    logic [RD_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [WR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [2*WR_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  mem_we;
    logic                  wr_bank;
    logic [WR_W-1:0]       rd_lo_addr, rd_hi_addr;

    assign wr_bank    = ~key_idx_q;
    assign mem_we     = en_wr & ~kill;
    assign rd_lo_addr = {rd_ptr_q, 1'b0};
    assign rd_hi_addr = {rd_ptr_q, 1'b1};

    // RAM contents survive kill; only the pointers are reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_bank][wr_ptr_q] <= key_round_wr;
        end
    end

    always_comb begin
        key_idx_d = key_idx_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_data_d = {mem_q[key_idx_q][rd_hi_addr], mem_q[key_idx_q][rd_lo_addr]};

        if (en_wr) begin
            wr_ptr_d = (wr_ptr_q == WR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (key_ready) begin
            rd_ptr_d = (rd_ptr_q == RD_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        // A swap restarts both pointers, overriding any same-cycle advance.
        if (switch_key) begin
            key_idx_d = ~key_idx_q;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            key_idx_q <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            key_idx_q <= key_idx_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign key_round_rd = rd_data_q;
    assign key_idx      = key_idx_q;

endmodule

// File: tb/tb_aes128_keyram_2key_switch.sv
// Directed bench for the ping-pong round-key RAM: counting, AES schedule load, bank swaps,
// concurrent read/write and kill/switch corner cases.
module tb_aes128_keyram_2key_switch;

    logic         clk = 1'b0;
    logic         kill;
    logic         en_wr;
    logic [63:0]  key_round_wr;
    logic         key_ready;
    logic         switch_key;
    logic [127:0] key_round_rd;
    logic         key_idx;

    int checks = 0;
    int errors = 0;

    // FIPS-197 key schedule for key 000102..0f, big-endian byte order.
    localparam logic [127:0] AES_RK [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    aes128_keyram_2key_switch dut (
        .clk          (clk),
        .kill         (kill),
        .en_wr        (en_wr),
        .key_round_wr (key_round_wr),
        .key_ready    (key_ready),
        .switch_key   (switch_key),
        .key_round_rd (key_round_rd),
        .key_idx      (key_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] brev(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127-8*i -: 8];
        return r;
    endfunction

    function automatic logic [127:0] pat(input int k, input int base);
        return {64'(base + 2*k + 1), 64'(base + 2*k)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_half(input logic [63:0] d);
        en_wr = 1'b1;
        key_round_wr = d;
        tick();
        en_wr = 1'b0;
    endtask

    // After return, key_round_rd reflects the advanced pointer.
    task automatic pulse_ready();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        tick();
    endtask

    task automatic do_switch(input logic exp_idx, input logic [127:0] exp_rd0);
        switch_key = 1'b1;
        tick();
        switch_key = 1'b0;
        check("switch_idx", 128'(key_idx), 128'(exp_idx));
        tick();
        check("switch_rd0", key_round_rd, exp_rd0);
    endtask

    initial begin
        int ptr;
        logic [127:0] rk;
        logic [127:0] exp;

        kill = 1'b1; en_wr = 1'b0; key_round_wr = '0; key_ready = 1'b0; switch_key = 1'b0;

        // 1) reset and free-running read pointer
        repeat (5) tick();
        check("rst_idx", 128'(key_idx), 128'h0);
        check("rst_rd", key_round_rd, 128'h0);
        kill = 1'b0;
        for (int i = 0; i < 11; i++) begin
            pulse_ready();
            tick(); tick();
            check("t1_idx", 128'(key_idx), 128'h0);
        end

        // 2) counting pattern into bank 1
        for (int h = 0; h < 22; h++) write_half(64'(h));
        do_switch(1'b1, {64'h1, 64'h0});
        for (int k = 1; k <= 10; k++) begin
            pulse_ready();
            check("t2_rd", key_round_rd, pat(k, 0));
        end
        check("t2_rd10", key_round_rd, {64'h15, 64'h14});

        // 3/4) AES schedule into bank 0 while reading bank 1
        ptr = 10;
        for (int h = 0; h < 22; h++) begin
            rk = brev(AES_RK[h/2]);
            en_wr = 1'b1;
            key_round_wr = (h % 2 == 0) ? rk[63:0] : rk[127:64];
            key_ready = (h % 4 == 1);
            exp = pat(ptr, 0);
            if (key_ready) ptr = (ptr == 10) ? 0 : ptr + 1;
            tick();
            check("t4_conc_rd", key_round_rd, exp);
        end
        en_wr = 1'b0;
        key_ready = 1'b0;
        do_switch(1'b0, 128'h0f0e0d0c0b0a09080706050403020100);
        pulse_ready();
        check("t3_rd1", key_round_rd, 128'hfe76abd6f178a6da_fa72afd2fd74aad6);
        for (int k = 2; k <= 10; k++) begin
            pulse_ready();
            check("t3_rdk", key_round_rd, brev(AES_RK[k]));
        end
        check("t3_rd10", key_round_rd, 128'hc5302b4d8ba707f3_174a94e37f1d1113);

        // 5) ping-pong back to bank 1 and read-pointer wrap
        for (int h = 0; h < 22; h++) write_half(64'(h));
        do_switch(1'b1, {64'h1, 64'h0});
        for (int k = 1; k <= 10; k++) pulse_ready();
        check("t5_rd10", key_round_rd, {64'h15, 64'h14});
        pulse_ready();
        check("t5_wrap", key_round_rd, {64'h1, 64'h0});

        // 6a) switch and key_ready together
        pulse_ready();
        check("t6_rd1", key_round_rd, {64'h3, 64'h2});
        switch_key = 1'b1;
        key_ready = 1'b1;
        tick();
        switch_key = 1'b0;
        key_ready = 1'b0;
        check("t6_sw_idx", 128'(key_idx), 128'h0);
        tick();
        check("t6_sw_rd0", key_round_rd, brev(AES_RK[0]));

        // 6b) kill in the middle of a bank-1 write
        for (int h = 0; h < 5; h++) write_half(64'hdead_0000 + 64'(h));
        en_wr = 1'b1;
        key_round_wr = 64'hdead_beef;
        kill = 1'b1;
        tick();
        kill = 1'b0;
        en_wr = 1'b0;
        check("t6_kill_idx", 128'(key_idx), 128'h0);
        check("t6_kill_rd", key_round_rd, 128'h0);
        tick();
        check("t6_kill_ram", key_round_rd, brev(AES_RK[0]));
        for (int h = 0; h < 22; h++) write_half(64'h100 + 64'(h));
        do_switch(1'b1, pat(0, 'h100));
        pulse_ready();
        check("t6_kill_rd1", key_round_rd, pat(1, 'h100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
